// File: rtl/router_pkg.sv
// Shared types and constants for the router output arbiter.
// A flit is DATA_W bits wide and its MSB marks the last flit of a packet.
package router_pkg;

  localparam int DATA_W   = 11;
  localparam int TAIL_BIT = DATA_W - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_0 = 2'd1,
    ST_GRANT_1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/router_output_arbiter_if.sv
// Bundles the two input-controller request channels and the registered output channel.
// A flit moves on any rising edge where its valid (req_x / out_valid) and ready are both 1.
interface router_output_arbiter_if #(
  parameter int DATA_W = router_pkg::DATA_W
);

  logic              req_0;
  logic [DATA_W-1:0] data_in_0;
  logic              ready_0;
  logic              req_1;
  logic [DATA_W-1:0] data_in_1;
  logic              ready_1;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport slave (
    input  req_0, data_in_0, req_1, data_in_1, out_ready,
    output ready_0, ready_1, out_valid, out_data
  );

  modport master (
    output req_0, data_in_0, req_1, data_in_1, out_ready,
    input  ready_0, ready_1, out_valid, out_data
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright; on a tie the
// input named by ptr wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = ptr;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// Output-port arbiter: grants one input for a whole packet (held until the
// tail flit transfers) and forwards flits through a single output register.
module router_output_arbiter
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  router_output_arbiter_if.slave  bus,
  output arb_state_e              dbg_state,
  output logic                    dbg_ptr
);

  arb_state_e        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic              gnt_valid;
  logic              gnt_idx;
  logic              can_accept;
  logic              xfer_0, xfer_1;
  logic              tail_0, tail_1;

  rr_arb2 u_rr_arb2 (
    .req       ({bus.req_1, bus.req_0}),
    .ptr       (ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // The output register can take a new flit when empty or being drained now.
  assign can_accept  = !out_valid_q || bus.out_ready;
  assign bus.ready_0 = (state_q == ST_GRANT_0) && can_accept;
  assign bus.ready_1 = (state_q == ST_GRANT_1) && can_accept;

  assign xfer_0 = bus.req_0 && bus.ready_0;
  assign xfer_1 = bus.req_1 && bus.ready_1;
  assign tail_0 = bus.data_in_0[DATA_W-1];
  assign tail_1 = bus.data_in_1[DATA_W-1];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = gnt_idx ? ST_GRANT_1 : ST_GRANT_0;
        end
      end
      ST_GRANT_0: begin
        // Hand straight over to a waiting input 1 so no IDLE bubble appears.
        if (xfer_0 && tail_0) begin
          ptr_d   = 1'b1;
          state_d = bus.req_1 ? ST_GRANT_1 : ST_IDLE;
        end
      end
      ST_GRANT_1: begin
        if (xfer_1 && tail_1) begin
          ptr_d   = 1'b0;
          state_d = bus.req_0 ? ST_GRANT_0 : ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (xfer_0) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.data_in_0;
    end else if (xfer_1) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.data_in_1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign dbg_state     = state_q;
  assign dbg_ptr       = ptr_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// Directed bench for router_output_arbiter: per-cycle vector table for the
// packet scenarios plus a hand-written asynchronous-reset sequence.
module tb_router_output_arbiter;
  import router_pkg::*;

  localparam int W = router_pkg::DATA_W;

  typedef struct {
    logic         rst;
    logic         r0;
    logic [W-1:0] d0;
    logic         r1;
    logic [W-1:0] d1;
    logic         ordy;
    logic         e_rdy0;
    logic         e_rdy1;
    arb_state_e   e_st;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic         e_ptr;
  } vec_t;

  logic       clk;
  logic       reset_n;
  arb_state_e dbg_state;
  logic       dbg_ptr;
  int         n_vec;
  int         n_fail;
  vec_t       tbl[$];

  router_output_arbiter_if #(.DATA_W(W)) bus ();

  router_output_arbiter #(.DATA_W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_ptr   (dbg_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, want %0h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [W-1:0] d0, input logic r1,
                       input logic [W-1:0] d1, input logic ordy);
    bus.req_0     = r0;
    bus.data_in_0 = d0;
    bus.req_1     = r1;
    bus.data_in_1 = d1;
    bus.out_ready = ordy;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic add(input logic rst, input logic r0, input logic [W-1:0] d0,
                     input logic r1, input logic [W-1:0] d1, input logic ordy,
                     input logic e_rdy0, input logic e_rdy1, input arb_state_e e_st,
                     input logic e_ov, input logic [W-1:0] e_od, input logic e_ptr);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.ordy = ordy;
    v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1; v.e_st = e_st;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ptr = e_ptr;
    tbl.push_back(v);
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    drive(1'b0, '0, 1'b0, '0, 1'b1);

    // Expected values: ready is checked before the edge, the rest after it.
    // 3-flit packet from input 0 with out_ready held high.
    add(1, 1, 11'h005, 0, 11'h000, 1,  0, 0, ST_GRANT_0, 0, 11'h000, 0);
    add(0, 1, 11'h005, 0, 11'h000, 1,  1, 0, ST_GRANT_0, 1, 11'h005, 0);
    add(0, 1, 11'h0AA, 0, 11'h000, 1,  1, 0, ST_GRANT_0, 1, 11'h0AA, 0);
    add(0, 1, 11'h4FF, 0, 11'h000, 1,  1, 0, ST_IDLE,    1, 11'h4FF, 1);
    add(0, 0, 11'h000, 0, 11'h000, 1,  0, 0, ST_IDLE,    0, 11'h4FF, 1);
    // Both request from reset, single-flit packets.
    add(1, 1, 11'h401, 1, 11'h402, 1,  0, 0, ST_GRANT_0, 0, 11'h000, 0);
    add(0, 1, 11'h401, 1, 11'h402, 1,  1, 0, ST_GRANT_1, 1, 11'h401, 1);
    add(0, 0, 11'h000, 1, 11'h402, 1,  0, 1, ST_IDLE,    1, 11'h402, 0);
    add(0, 0, 11'h000, 0, 11'h000, 1,  0, 0, ST_IDLE,    0, 11'h402, 0);
    // Input 1 raises req mid-packet of input 0; direct handover.
    add(1, 1, 11'h010, 0, 11'h000, 1,  0, 0, ST_GRANT_0, 0, 11'h000, 0);
    add(0, 1, 11'h010, 1, 11'h020, 1,  1, 0, ST_GRANT_0, 1, 11'h010, 0);
    add(0, 1, 11'h011, 1, 11'h020, 1,  1, 0, ST_GRANT_0, 1, 11'h011, 0);
    add(0, 1, 11'h412, 1, 11'h020, 1,  1, 0, ST_GRANT_1, 1, 11'h412, 1);
    add(0, 0, 11'h000, 1, 11'h020, 1,  0, 1, ST_GRANT_1, 1, 11'h020, 1);
    add(0, 0, 11'h000, 1, 11'h421, 1,  0, 1, ST_IDLE,    1, 11'h421, 0);
    add(0, 0, 11'h000, 0, 11'h000, 1,  0, 0, ST_IDLE,    0, 11'h421, 0);
    // Downstream stalls for 4 cycles with a flit held.
    add(1, 1, 11'h030, 1, 11'h055, 1,  0, 0, ST_GRANT_0, 0, 11'h000, 0);
    add(0, 1, 11'h030, 1, 11'h055, 0,  1, 0, ST_GRANT_0, 1, 11'h030, 0);
    add(0, 1, 11'h431, 1, 11'h055, 0,  0, 0, ST_GRANT_0, 1, 11'h030, 0);
    add(0, 1, 11'h431, 1, 11'h055, 0,  0, 0, ST_GRANT_0, 1, 11'h030, 0);
    add(0, 1, 11'h431, 1, 11'h055, 0,  0, 0, ST_GRANT_0, 1, 11'h030, 0);
    add(0, 1, 11'h431, 1, 11'h055, 0,  0, 0, ST_GRANT_0, 1, 11'h030, 0);
    add(0, 1, 11'h431, 0, 11'h000, 1,  1, 0, ST_IDLE,    1, 11'h431, 1);
    add(0, 0, 11'h000, 0, 11'h000, 1,  0, 0, ST_IDLE,    0, 11'h431, 1);
    // Input 0 runs dry for 2 cycles mid-packet; input 1 stays blocked.
    add(1, 1, 11'h040, 0, 11'h000, 1,  0, 0, ST_GRANT_0, 0, 11'h000, 0);
    add(0, 1, 11'h040, 0, 11'h000, 1,  1, 0, ST_GRANT_0, 1, 11'h040, 0);
    add(0, 0, 11'h000, 1, 11'h450, 1,  1, 0, ST_GRANT_0, 0, 11'h040, 0);
    add(0, 0, 11'h000, 1, 11'h450, 1,  1, 0, ST_GRANT_0, 0, 11'h040, 0);
    add(0, 1, 11'h041, 1, 11'h450, 1,  1, 0, ST_GRANT_0, 1, 11'h041, 0);
    add(0, 1, 11'h442, 1, 11'h450, 1,  1, 0, ST_GRANT_1, 1, 11'h442, 1);
    add(0, 0, 11'h000, 1, 11'h450, 1,  0, 1, ST_IDLE,    1, 11'h450, 0);
    add(0, 0, 11'h000, 0, 11'h000, 1,  0, 0, ST_IDLE,    0, 11'h450, 0);

    do_reset();
    chk("reset_state", -1, 32'(dbg_state), 32'(ST_IDLE));
    chk("reset_ov",    -1, 32'(bus.out_valid), 32'h0);
    chk("reset_od",    -1, 32'(bus.out_data), 32'h0);
    chk("reset_rdy0",  -1, 32'(bus.ready_0), 32'h0);
    chk("reset_rdy1",  -1, 32'(bus.ready_1), 32'h0);
    chk("reset_ptr",   -1, 32'(dbg_ptr), 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].r0, tbl[i].d0, tbl[i].r1, tbl[i].d1, tbl[i].ordy);
      #1;
      chk("ready_0", i, 32'(bus.ready_0), 32'(tbl[i].e_rdy0));
      chk("ready_1", i, 32'(bus.ready_1), 32'(tbl[i].e_rdy1));
      @(posedge clk);
      #1;
      chk("state",     i, 32'(dbg_state), 32'(tbl[i].e_st));
      chk("out_valid", i, 32'(bus.out_valid), 32'(tbl[i].e_ov));
      chk("out_data",  i, 32'(bus.out_data), 32'(tbl[i].e_od));
      chk("ptr",       i, 32'(dbg_ptr), 32'(tbl[i].e_ptr));
    end

    // Asynchronous reset in the middle of an input-0 packet.
    do_reset();
    drive(1'b1, 11'h060, 1'b0, 11'h000, 1'b1);
    @(posedge clk); #1;
    chk("mid_grant", 100, 32'(dbg_state), 32'(ST_GRANT_0));
    @(posedge clk); #1;
    drive(1'b1, 11'h061, 1'b0, 11'h000, 1'b1);
    @(posedge clk); #1;
    chk("mid_od", 101, 32'(bus.out_data), 32'h061);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_state", 102, 32'(dbg_state), 32'(ST_IDLE));
    chk("async_ov",    103, 32'(bus.out_valid), 32'h0);
    chk("async_od",    104, 32'(bus.out_data), 32'h0);
    chk("async_rdy0",  105, 32'(bus.ready_0), 32'h0);
    chk("async_ptr",   106, 32'(dbg_ptr), 32'h0);
    drive(1'b1, 11'h470, 1'b1, 11'h471, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("held_ov", 107, 32'(bus.out_valid), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_grant", 108, 32'(dbg_state), 32'(ST_GRANT_0));
    chk("post_ov",    109, 32'(bus.out_valid), 32'h0);
    @(posedge clk); #1;
    chk("post_od0",   110, 32'(bus.out_data), 32'h470);
    chk("post_st1",   111, 32'(dbg_state), 32'(ST_GRANT_1));
    chk("post_ptr1",  112, 32'(dbg_ptr), 32'h1);
    drive(1'b0, 11'h000, 1'b1, 11'h471, 1'b1);
    @(posedge clk); #1;
    chk("post_od1",   113, 32'(bus.out_data), 32'h471);
    chk("post_idle",  114, 32'(dbg_state), 32'(ST_IDLE));
    chk("post_ptr0",  115, 32'(dbg_ptr), 32'h0);
    drive(1'b0, 11'h000, 1'b0, 11'h000, 1'b1);
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
